// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bundle between the fetch stage and imem.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_data);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_data);
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, runs the imem handshake and feeds the F/D register with
// instructions or NOP bubbles. Define FETCH_STATS_EN to add the bubble_cnt_o counter.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter int unsigned PC_STEP  = 4,
  parameter logic [31:0] NOP_WORD = 32'hdc000000
) (
  input  logic         clk,
  input  logic         rstd,
  input  logic         stall_i,
  input  logic         redirect_i,
  input  logic [31:0]  redirect_pc_i,
  input  logic         resolve_i,
  fetch_unit_if.master imem,
  output logic [31:0]  pc_out_o,
  output logic [31:0]  ins_out_o
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]  bubble_cnt_o
`endif
);

  typedef enum logic [1:0] {RUN, HOLD, JWAIT, DROP} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] ins_out_q, ins_out_d;
  logic [31:0] hold_ins_q, hold_ins_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] drop_addr_q, drop_addr_d;
  logic        req_raw;
  logic        load_nop;

  function automatic logic is_jump(input logic [31:0] ins);
    logic [5:0] op;
    op = ins[31:26];
    return (op == 6'd32) || (op == 6'd33) || (op == 6'd34) || (op == 6'd35) ||
           (op == 6'd40) || (op == 6'd41) || (op == 6'd42);
  endfunction

  always_ff @(posedge clk) begin
    if (rstd) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      pc_out_q    <= RESET_PC;
      ins_out_q   <= NOP_WORD;
      hold_ins_q  <= NOP_WORD;
      hold_pc_q   <= RESET_PC;
      drop_addr_q <= RESET_PC;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pc_out_q    <= pc_out_d;
      ins_out_q   <= ins_out_d;
      hold_ins_q  <= hold_ins_d;
      hold_pc_q   <= hold_pc_d;
      drop_addr_q <= drop_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pc_out_d    = pc_out_q;
    ins_out_d   = ins_out_q;
    hold_ins_d  = hold_ins_q;
    hold_pc_d   = hold_pc_q;
    drop_addr_d = drop_addr_q;
    req_raw     = 1'b0;
    load_nop    = 1'b0;

    unique case (state_q)
      RUN: begin
        req_raw = 1'b1;
        if (imem.imem_ack) begin
          pc_d = pc_q + 32'(PC_STEP);
          if (!stall_i) begin
            ins_out_d = imem.imem_data;
            pc_out_d  = pc_q;
            if (is_jump(imem.imem_data)) state_d = JWAIT;
          end else begin
            hold_ins_d = imem.imem_data;
            hold_pc_d  = pc_q;
            state_d    = HOLD;
          end
        end else if (!stall_i) begin
          ins_out_d = NOP_WORD;
          load_nop  = 1'b1;
        end
      end
      HOLD: begin
        if (!stall_i) begin
          ins_out_d = hold_ins_q;
          pc_out_d  = hold_pc_q;
          state_d   = is_jump(hold_ins_q) ? JWAIT : RUN;
        end
      end
      JWAIT: begin
        if (!stall_i) begin
          ins_out_d = NOP_WORD;
          load_nop  = 1'b1;
        end
        if (resolve_i) state_d = RUN;
      end
      DROP: begin
        req_raw = 1'b1;
        if (!stall_i) begin
          ins_out_d = NOP_WORD;
          load_nop  = 1'b1;
        end
        if (imem.imem_ack) state_d = RUN;
      end
      default: state_d = RUN;
    endcase

    // Redirect overrides everything above: any buffered or same-cycle data is thrown away,
    // and an unacked request must still be drained at its original address.
    if (redirect_i) begin
      pc_d      = redirect_pc_i;
      pc_out_d  = pc_out_q;
      ins_out_d = NOP_WORD;
      load_nop  = 1'b1;
      if (req_raw && !imem.imem_ack) begin
        state_d     = DROP;
        drop_addr_d = (state_q == DROP) ? drop_addr_q : pc_q;
      end else begin
        state_d = RUN;
      end
    end
  end

  assign imem.imem_req  = req_raw & ~rstd;
  assign imem.imem_addr = (state_q == DROP) ? drop_addr_q : pc_q;
  assign pc_out_o       = pc_out_q;
  assign ins_out_o      = ins_out_q;

`ifdef FETCH_STATS_EN
  logic [31:0] bubble_cnt_q;

  always_ff @(posedge clk) begin
    if (rstd)                                   bubble_cnt_q <= '0;
    else if (load_nop && bubble_cnt_q != '1)    bubble_cnt_q <= bubble_cnt_q + 32'd1;
  end

  assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: sequential fetch, jumps, redirect drop, stall hold, reset.
module tb_fetch_unit;

  localparam logic [31:0] NOP  = 32'hdc000000;
  localparam logic [31:0] WORD = 32'h04000000;

  logic        clk = 1'b0;
  logic        rstd = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirectPc = '0;
  logic        resolve = 1'b0;
  logic [31:0] pcOut, insOut;
`ifdef FETCH_STATS_EN
  logic [31:0] bubbleCnt;
`endif

  logic        autoAck = 1'b1;
  logic        addrTag = 1'b0;
  logic        manAck = 1'b0;
  logic [31:0] manData = '0;
  logic [31:0] jumpAt = 32'hfffffff0;
  logic [31:0] jumpWord = 32'h80000010;
  logic [31:0] memWord;

  int checks = 0;
  int errors = 0;

  fetch_unit_if memIf();

  fetch_unit dut (
    .clk           (clk),
    .rstd          (rstd),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirectPc),
    .resolve_i     (resolve),
    .imem          (memIf),
    .pc_out_o      (pcOut),
    .ins_out_o     (insOut)
`ifdef FETCH_STATS_EN
    ,
    .bubble_cnt_o  (bubbleCnt)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: zero-wait ack returning a fixed word (optionally tagged with the address).
  always_comb begin
    memWord = WORD | (addrTag ? memIf.imem_addr : 32'h0);
    if (memIf.imem_addr == jumpAt) memWord = jumpWord;
    memIf.imem_ack  = autoAck ? memIf.imem_req : manAck;
    memIf.imem_data = autoAck ? memWord : manData;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rstd = 1'b1;
    step();
    rstd = 1'b0;
  endtask

  task automatic test_reset();
    autoAck = 1'b1; stall = 1'b0;
    rstd = 1'b1;
    step();
    checks++; if (memIf.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b expected 0", memIf.imem_req); end
    checks++; if (pcOut !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc_out: got %h expected 00000000", pcOut); end
    checks++; if (insOut !== NOP) begin errors++; $display("[TB] FAIL reset_ins_out: got %h expected %h", insOut, NOP); end
`ifdef FETCH_STATS_EN
    checks++; if (bubbleCnt !== 32'h0) begin errors++; $display("[TB] FAIL reset_bubble: got %0d expected 0", bubbleCnt); end
`endif
    rstd = 1'b0;
    #1;
    checks++; if (memIf.imem_req !== 1'b1 || memIf.imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL first_req: got req=%b addr=%h expected req=1 addr=00000000", memIf.imem_req, memIf.imem_addr); end
  endtask

  task automatic test_sequential();
    logic [31:0] expPc;
    doReset();
    for (int i = 0; i < 4; i++) begin
      step();
      expPc = 32'(i * 4);
      checks++; if (pcOut !== expPc || insOut !== WORD) begin errors++; $display("[TB] FAIL seq_%0d: got pc=%h ins=%h expected pc=%h ins=%h", i, pcOut, insOut, expPc, WORD); end
    end
    checks++; if (memIf.imem_addr !== 32'h10) begin errors++; $display("[TB] FAIL seq_addr: got %h expected 00000010", memIf.imem_addr); end
  endtask

  task automatic test_jump_redirect();
    jumpAt = 32'h8; jumpWord = 32'h80000010;
    doReset();
    step(); step(); step();
    checks++; if (pcOut !== 32'h8 || insOut !== 32'h80000010) begin errors++; $display("[TB] FAIL jump_out: got pc=%h ins=%h expected pc=00000008 ins=80000010", pcOut, insOut); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (insOut !== NOP || memIf.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL jwait_%0d: got ins=%h req=%b expected ins=%h req=0", i, insOut, memIf.imem_req, NOP); end
    end
    redirect = 1'b1; redirectPc = 32'h40;
    step();
    redirect = 1'b0;
    #1;
    checks++; if (memIf.imem_req !== 1'b1 || memIf.imem_addr !== 32'h40) begin errors++; $display("[TB] FAIL redirect_addr: got req=%b addr=%h expected req=1 addr=00000040", memIf.imem_req, memIf.imem_addr); end
    step();
    checks++; if (pcOut !== 32'h40 || insOut !== WORD) begin errors++; $display("[TB] FAIL redirect_fetch: got pc=%h ins=%h expected pc=00000040 ins=%h", pcOut, insOut, WORD); end
    jumpAt = 32'hfffffff0;
  endtask

  task automatic test_resolve();
    jumpAt = 32'h8; jumpWord = 32'h84000000;
    doReset();
    step(); step(); step();
    checks++; if (pcOut !== 32'h8 || insOut !== 32'h84000000) begin errors++; $display("[TB] FAIL resolve_jump: got pc=%h ins=%h expected pc=00000008 ins=84000000", pcOut, insOut); end
    step(); step();
    checks++; if (insOut !== NOP || memIf.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL resolve_wait: got ins=%h req=%b expected ins=%h req=0", insOut, memIf.imem_req, NOP); end
    resolve = 1'b1;
    step();
    resolve = 1'b0;
    #1;
    checks++; if (memIf.imem_req !== 1'b1 || memIf.imem_addr !== 32'hc) begin errors++; $display("[TB] FAIL resolve_addr: got req=%b addr=%h expected req=1 addr=0000000c", memIf.imem_req, memIf.imem_addr); end
    step();
    checks++; if (pcOut !== 32'hc || insOut !== WORD) begin errors++; $display("[TB] FAIL resolve_fetch: got pc=%h ins=%h expected pc=0000000c ins=%h", pcOut, insOut, WORD); end
    jumpAt = 32'hfffffff0;
  endtask

  task automatic test_drop();
    autoAck = 1'b0; manAck = 1'b0; manData = 32'h0badf00d;
    doReset();
    step();
    redirect = 1'b1; redirectPc = 32'h100;
    step();
    redirect = 1'b0;
    #1;
    checks++; if (memIf.imem_req !== 1'b1 || memIf.imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL drop_hold1: got req=%b addr=%h expected req=1 addr=00000000", memIf.imem_req, memIf.imem_addr); end
    manAck = 1'b1;
    step();
    manAck = 1'b0;
    #1;
    checks++; if (insOut !== NOP) begin errors++; $display("[TB] FAIL drop_discard: got %h expected %h", insOut, NOP); end
    checks++; if (memIf.imem_req !== 1'b1 || memIf.imem_addr !== 32'h100) begin errors++; $display("[TB] FAIL drop_newaddr: got req=%b addr=%h expected req=1 addr=00000100", memIf.imem_req, memIf.imem_addr); end
    autoAck = 1'b1;
    step();
    checks++; if (pcOut !== 32'h100 || insOut !== WORD) begin errors++; $display("[TB] FAIL drop_resume: got pc=%h ins=%h expected pc=00000100 ins=%h", pcOut, insOut, WORD); end
  endtask

  task automatic test_stall();
    logic [31:0] expPc;
    autoAck = 1'b1; addrTag = 1'b1;
    doReset();
    step();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (pcOut !== 32'h0 || insOut !== WORD) begin errors++; $display("[TB] FAIL stall_frozen_%0d: got pc=%h ins=%h expected pc=00000000 ins=%h", i, pcOut, insOut, WORD); end
    end
    checks++; if (memIf.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL stall_req: got %b expected 0", memIf.imem_req); end
    stall = 1'b0;
    for (int i = 1; i < 4; i++) begin
      step();
      expPc = 32'(i * 4);
      checks++; if (pcOut !== expPc || insOut !== (WORD | expPc)) begin errors++; $display("[TB] FAIL stall_release_%0d: got pc=%h ins=%h expected pc=%h ins=%h", i, pcOut, insOut, expPc, WORD | expPc); end
    end
    addrTag = 1'b0;
  endtask

  task automatic test_reset_mid();
    autoAck = 1'b1;
    doReset();
    for (int i = 0; i < 8; i++) step();
    autoAck = 1'b0; manAck = 1'b0;
    step();
    checks++; if (memIf.imem_req !== 1'b1 || memIf.imem_addr !== 32'h20) begin errors++; $display("[TB] FAIL mid_req: got req=%b addr=%h expected req=1 addr=00000020", memIf.imem_req, memIf.imem_addr); end
    doReset();
    checks++; if (pcOut !== 32'h0 || insOut !== NOP) begin errors++; $display("[TB] FAIL mid_reset: got pc=%h ins=%h expected pc=00000000 ins=%h", pcOut, insOut, NOP); end
`ifdef FETCH_STATS_EN
    checks++; if (bubbleCnt !== 32'h0) begin errors++; $display("[TB] FAIL mid_bubble0: got %0d expected 0", bubbleCnt); end
`endif
    step();
`ifdef FETCH_STATS_EN
    checks++; if (bubbleCnt !== 32'h1) begin errors++; $display("[TB] FAIL mid_bubble1: got %0d expected 1", bubbleCnt); end
`endif
    manAck = 1'b1; manData = WORD;
    step();
    manAck = 1'b0;
    checks++; if (pcOut !== 32'h0 || insOut !== WORD) begin errors++; $display("[TB] FAIL mid_fresh: got pc=%h ins=%h expected pc=00000000 ins=%h", pcOut, insOut, WORD); end
    autoAck = 1'b1;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_jump_redirect();
    test_resolve();
    test_drop();
    test_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
